keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Front end of the password door lock. Collects hex key presses from the keypad scanner and assembles them into the 32-bit code word that the password checker compares.
- Presents the assembled word on a held output with a one-cycle submit strobe.
- Uses the checker's alarm output to lock out further entry.
- Counterpart (producer side) of the password checker's `in` interface.

Parameters:
- DIGITS, 8, number of hex digits per code; code width = 4*DIGITS.
- TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles during entry. Used only with KEYPAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  5  0x00-0x0F hex digit; 0x10 ENTER; 0x11 CLEAR; 0x12-0x1F illegal.
- alarm_in  in  1  alarm level from the password checker.
- code_out  out  4*DIGITS  last submitted code; held until the next submit.
- code_valid  out  1  one-cycle pulse; code_out was updated this cycle.
- digit_count  out  $clog2(DIGITS+1)  digits currently buffered.
- entry_err  out  1  one-cycle pulse on a rejected key or sequence.
- locked  out  1  high while entry is blocked by alarm.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset value: all outputs 0; internal buffer 0; state IDLE. Reset overrides every other input in the same cycle.
- States: IDLE, ENTRY, SUBMIT, LOCKED. All outputs are registered.
- IDLE:
  - digit key -> buf <= {buf[4*DIGITS-5:0], digit}, count <= 1, go to ENTRY.
  - ENTER -> entry_err pulse, stay in IDLE.
  - CLEAR -> no-op.
- ENTRY:
  - digit with count<DIGITS -> shift left by one nibble, new digit into the LSB nibble, count+1.
  - digit with count==DIGITS -> digit dropped, entry_err pulse, buffer unchanged.
  - ENTER with count==DIGITS -> go to SUBMIT.
  - ENTER with count<DIGITS -> entry_err pulse, clear buffer/count, go to IDLE.
  - CLEAR -> clear buffer/count, go to IDLE, no error.
- SUBMIT (exactly one cycle): code_out <= buf, code_valid=1, buffer/count cleared, then IDLE. Any key arriving in this cycle is ignored without error.
- Submit latency: code_valid and the new code_out are seen on the first edge after the ENTER edge.
- Illegal key_code (0x12-0x1F) in any state: ignored, entry_err pulse.
- alarm_in=1 in any state except reset:
  - go to LOCKED next cycle; buffer/count cleared; locked=1.
  - alarm_in has priority over a key in the same cycle: the key is discarded with no error pulse.
- LOCKED: all keys ignored, no errors. On alarm_in=0, go to IDLE and locked drops on the same edge.
- code_out never changes except in SUBMIT or on reset.
- Reset mid-entry discards the partial code; code_out returns to 0.
- digit_count tracks the register count and saturates at DIGITS.
- entry_err and code_valid are never high in the same cycle.

Optional Feature:
- Macro: KEYPAD_TIMEOUT_EN.
- Defined:
  - an inactivity counter runs only in ENTRY and is cleared on every key_valid;
  - when it reaches TIMEOUT_CYCLES-1 with no key: clear buffer/count, entry_err pulse, go to IDLE;
  - a key arriving in the expiry cycle takes priority and the timeout does not fire.
- Undefined: no counter; ENTRY waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- keypad_pkg holds:
  - constants KEY_ENTER=5'h10 and KEY_CLEAR=5'h11;
  - the state enum {IDLE, ENTRY, SUBMIT, LOCKED};
  - a helper function is_digit(key_code).
- One sub-module, entry_timeout_timer: counter with clear/enable inputs and an expire pulse output. Instantiated only under KEYPAD_TIMEOUT_EN.

Test Plan:
- Basic submit: keys 1,2,3,4,5,6,7,8 then ENTER -> one cycle later code_out=0x12345678, code_valid=1 for exactly 1 cycle, digit_count=0.
- Short entry: keys 1,2,4,2 then ENTER -> entry_err pulse; code_out keeps its previous 0x12345678; digit_count=0.
- Overflow then clear:
  - 9 digits 1..9 -> 9th digit gives entry_err, digit_count stays 8;
  - ENTER -> code_out=0x12345678;
  - then keys A,B,CLEAR -> digit_count=0, no error.
- Lockout: alarm_in=1 during entry of 0x1234 -> locked=1 next cycle, further keys ignored; alarm_in=0 -> IDLE; then key entry of 0x1234abcd + ENTER -> code_out=0x1234ABCD.
- Reset mid-entry: reset=1 after keys 1,2,a,c -> all outputs 0, state IDLE. Illegal key 0x15 -> entry_err pulse only.
- With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES=20: one digit, then 19 idle cycles -> entry_err pulse and digit_count=0. Same case with a key on cycle 19 -> no timeout, digit_count=2.

Source files
------------

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the keypad entry front end of the door lock.
//   - KEY_ENTER / KEY_CLEAR : special key codes from the keypad scanner
//   - state_t               : entry controller states
//   - key_kind_t            : decoded meaning of a 5-bit key code
//   - is_digit()            : true for hex digit keys 0x00-0x0F
//   - classify_key()        : maps a raw key code onto key_kind_t
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [4:0] KEY_ENTER = 5'h10;
    localparam logic [4:0] KEY_CLEAR = 5'h11;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        SUBMIT,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        KEY_DIGIT,
        KEY_ENT,
        KEY_CLR,
        KEY_BAD
    } key_kind_t;

    // Digits occupy the lower half of the code space, so bit 4 alone decides.
    function automatic logic is_digit(input logic [4:0] key_code);
        return (key_code[4] == 1'b0);
    endfunction

    function automatic key_kind_t classify_key(input logic [4:0] key_code);
        key_kind_t kind;
        if (is_digit(key_code)) begin
            kind = KEY_DIGIT;
        end else if (key_code == KEY_ENTER) begin
            kind = KEY_ENT;
        end else if (key_code == KEY_CLEAR) begin
            kind = KEY_CLR;
        end else begin
            kind = KEY_BAD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/entry_timeout_timer.sv
// ---------------------------------------------------------------------------
// entry_timeout_timer
//   Inactivity timer for code entry. Counts clock cycles while enabled and
//   not cleared; raises a single-cycle expire when the TIMEOUT_CYCLES-1'th
//   consecutive quiet cycle is being counted.
//
//   Ports:
//     clk     in  1  system clock, rising edge
//     reset   in  1  synchronous, active-high reset
//     enable  in  1  count only while high (entry in progress)
//     clear   in  1  restart the count (a key was pressed this cycle)
//     expire  out 1  combinational pulse; the owner registers the reaction
// ---------------------------------------------------------------------------
module entry_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // The counter holds the number of quiet cycles already seen; expiry is
    // flagged in the cycle whose count brings the total to TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !enable || expire) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// ---------------------------------------------------------------------------
// keypad_entry
//   Producer side of the password checker input. Collects hex key presses,
//   shifts them into a code word of DIGITS nibbles and, on ENTER with a full
//   buffer, publishes the word on code_out with a one-cycle code_valid.
//   An alarm from the checker locks out entry until it is released.
//
//   Optional feature (compile-time macro KEYPAD_TIMEOUT_EN):
//     defined   - an inactivity timer aborts entry after TIMEOUT_CYCLES-1
//                 quiet cycles with an entry_err pulse.
//     undefined - entry waits indefinitely; TIMEOUT_CYCLES has no effect.
//
//   Ports:
//     clk          in  1                  system clock, rising edge
//     reset        in  1                  synchronous, active-high reset
//     key_valid    in  1                  key_code is valid this cycle
//     key_code     in  5                  0x00-0x0F digit, 0x10 ENTER,
//                                         0x11 CLEAR, 0x12-0x1F illegal
//     alarm_in     in  1                  alarm level from the checker
//     code_out     out 4*DIGITS           last submitted code (held)
//     code_valid   out 1                  pulse: code_out updated
//     digit_count  out $clog2(DIGITS+1)   digits currently buffered
//     entry_err    out 1                  pulse: rejected key or sequence
//     locked       out 1                  entry blocked by alarm
//   All outputs are registered.
// ---------------------------------------------------------------------------
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic [4:0]                   key_code,
    input  logic                         alarm_in,
    output logic [4*DIGITS-1:0]          code_out,
    output logic                         code_valid,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_err,
    output logic                         locked
);

    localparam int CODE_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

    state_t            state;
    state_t            state_next;
    logic [CODE_W-1:0] code_buf;
    logic [CODE_W-1:0] buf_next;
    logic [CNT_W-1:0]  count_next;
    logic [CODE_W-1:0] code_next;
    logic              err_next;
    logic              valid_next;
    logic              locked_next;
    key_kind_t         kind;
    logic              timeout_expire;

    // New digits enter at the least significant nibble, so the first key
    // typed ends up in the most significant nibble of a full code.
    function automatic logic [CODE_W-1:0] shift_in(input logic [CODE_W-1:0] cur,
                                                   input logic [3:0]        nibble);
        return {cur[CODE_W-5:0], nibble};
    endfunction

    assign kind = classify_key(key_code);

`ifdef KEYPAD_TIMEOUT_EN
    entry_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ENTRY),
        .clear  (key_valid),
        .expire (timeout_expire)
    );
`else
    // Timeout compiled out: constant-false, written against the parameter
    // so the interface stays identical in both builds.
    assign timeout_expire = (TIMEOUT_CYCLES < 0);
`endif

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            code_buf    <= '0;
            digit_count <= '0;
            code_out    <= '0;
            code_valid  <= 1'b0;
            entry_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            code_buf    <= buf_next;
            digit_count <= count_next;
            code_out    <= code_next;
            code_valid  <= valid_next;
            entry_err   <= err_next;
            locked      <= locked_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        buf_next   = code_buf;
        count_next = digit_count;
        code_next  = code_out;
        err_next   = 1'b0;
        valid_next = 1'b0;

        if (alarm_in) begin
            // Alarm wins over any key, and a pending submit is abandoned.
            state_next = LOCKED;
            buf_next   = '0;
            count_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        unique case (kind)
                            KEY_DIGIT: begin
                                buf_next   = shift_in(code_buf, key_code[3:0]);
                                count_next = CNT_W'(1);
                                state_next = ENTRY;
                            end
                            KEY_ENT: err_next = 1'b1;
                            KEY_CLR: err_next = 1'b0;
                            KEY_BAD: err_next = 1'b1;
                        endcase
                    end
                end

                ENTRY: begin
                    if (key_valid) begin
                        unique case (kind)
                            KEY_DIGIT: begin
                                if (digit_count < FULL) begin
                                    buf_next   = shift_in(code_buf, key_code[3:0]);
                                    count_next = digit_count + CNT_W'(1);
                                end else begin
                                    err_next = 1'b1;
                                end
                            end
                            KEY_ENT: begin
                                if (digit_count == FULL) begin
                                    state_next = SUBMIT;
                                end else begin
                                    err_next   = 1'b1;
                                    buf_next   = '0;
                                    count_next = '0;
                                    state_next = IDLE;
                                end
                            end
                            KEY_CLR: begin
                                buf_next   = '0;
                                count_next = '0;
                                state_next = IDLE;
                            end
                            KEY_BAD: err_next = 1'b1;
                        endcase
                    end else if (timeout_expire) begin
                        err_next   = 1'b1;
                        buf_next   = '0;
                        count_next = '0;
                        state_next = IDLE;
                    end
                end

                SUBMIT: begin
                    // Keys arriving here are dropped silently.
                    code_next  = code_buf;
                    valid_next = 1'b1;
                    buf_next   = '0;
                    count_next = '0;
                    state_next = IDLE;
                end

                LOCKED: begin
                    // alarm_in is low on this path, so the lock releases.
                    state_next = IDLE;
                end
            endcase
        end

        locked_next = (state_next == LOCKED);
    end

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
module tb_keypad_entry;

    localparam int DIGITS = 8;
    localparam int TMO    = 20;
    localparam logic [4:0] K_ENT = 5'h10;
    localparam logic [4:0] K_CLR = 5'h11;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        alarm_in;
    logic [31:0] code_out;
    logic        code_valid;
    logic [3:0]  digit_count;
    logic        entry_err;
    logic        locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_entry #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alarm_in    (alarm_in),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .digit_count (digit_count),
        .entry_err   (entry_err),
        .locked      (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the typed code is a queue of digits, a submit is a
    // pending flag, and the lockout is a single flag.
    int          q[$];
    bit          m_locked = 1'b0;
    bit          m_pend   = 1'b0;
    logic [31:0] m_code   = '0;
    bit          m_err    = 1'b0;
    bit          m_valid  = 1'b0;
    int          m_idle   = 0;
    bit          model_live = 1'b0;

    function automatic logic [31:0] pack_digits();
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = (v << 4) | 32'(q[i]);
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        m_err   = 1'b0;
        m_valid = 1'b0;
        if (reset) begin
            q.delete(); m_locked = 1'b0; m_pend = 1'b0; m_code = '0; m_idle = 0;
        end else if (alarm_in) begin
            q.delete(); m_pend = 1'b0; m_locked = 1'b1; m_idle = 0;
        end else if (m_locked) begin
            m_locked = 1'b0;
        end else if (m_pend) begin
            m_code  = pack_digits();
            m_valid = 1'b1;
            q.delete();
            m_pend  = 1'b0;
        end else if (key_valid) begin
            m_idle = 0;
            if (key_code < 5'h10) begin
                if (q.size() < DIGITS) q.push_back(int'(key_code));
                else m_err = 1'b1;
            end else if (key_code == K_ENT) begin
                if (q.size() == DIGITS) m_pend = 1'b1;
                else begin m_err = 1'b1; q.delete(); end
            end else if (key_code == K_CLR) begin
                q.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (q.size() > 0) begin
`ifdef KEYPAD_TIMEOUT_EN
            m_idle++;
            if (m_idle == TMO - 1) begin
                m_err = 1'b1;
                q.delete();
                m_idle = 0;
            end
`endif
        end
        model_live = 1'b1;
    end

    // Compare every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check("code_out",    code_out,            m_code);
            check("code_valid",  32'(code_valid),     32'(m_valid));
            check("digit_count", 32'(digit_count),    32'(q.size()));
            check("entry_err",   32'(entry_err),      32'(m_err));
            check("locked",      32'(locked),         32'(m_locked));
        end
    end

    // Called at a falling edge; the key is sampled on the next rising edge and
    // the task returns on the falling edge after it.
    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish by 200000ns");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = '0; alarm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_code",   code_out,          32'h0);
        check("rst_count",  32'(digit_count),  32'd0);
        check("rst_locked", 32'(locked),       32'd0);
        reset = 1'b0;

        // Basic submit
        for (int i = 1; i <= 8; i++) press(5'(i));
        check("full_count", 32'(digit_count), 32'd8);
        press(K_ENT);
        check("valid_not_yet", 32'(code_valid), 32'd0);
        @(negedge clk);
        check("submit_code",  code_out,          32'h12345678);
        check("submit_valid", 32'(code_valid),   32'd1);
        check("submit_count", 32'(digit_count),  32'd0);
        @(negedge clk);
        check("valid_one_cycle", 32'(code_valid), 32'd0);

        // Short entry
        press(5'h1); press(5'h2); press(5'h4); press(5'h2);
        press(K_ENT);
        check("short_err",   32'(entry_err),   32'd1);
        check("short_count", 32'(digit_count), 32'd0);
        check("short_code",  code_out,         32'h12345678);
        @(negedge clk);
        check("short_err_pulse", 32'(entry_err), 32'd0);

        // Overflow then clear
        for (int i = 1; i <= 9; i++) press(5'(i));
        check("ovf_err",   32'(entry_err),   32'd1);
        check("ovf_count", 32'(digit_count), 32'd8);
        press(K_ENT);
        @(negedge clk);
        check("ovf_code",  code_out,        32'h12345678);
        check("ovf_valid", 32'(code_valid), 32'd1);
        press(5'hA); press(5'hB);
        check("ab_count", 32'(digit_count), 32'd2);
        press(K_CLR);
        check("clr_count", 32'(digit_count), 32'd0);
        check("clr_err",   32'(entry_err),   32'd0);

        // Lockout
        press(5'h1); press(5'h2); press(5'h3); press(5'h4);
        alarm_in = 1'b1;
        @(negedge clk);
        check("lock_on",    32'(locked),      32'd1);
        check("lock_count", 32'(digit_count), 32'd0);
        press(5'h5);
        check("lock_key_count", 32'(digit_count), 32'd0);
        check("lock_key_err",   32'(entry_err),   32'd0);
        alarm_in = 1'b0;
        @(negedge clk);
        check("lock_off", 32'(locked), 32'd0);
        press(5'h1); press(5'h2); press(5'h3); press(5'h4);
        press(5'hA); press(5'hB); press(5'hC); press(5'hD);
        press(K_ENT);
        @(negedge clk);
        check("relock_code",  code_out,        32'h1234ABCD);
        check("relock_valid", 32'(code_valid), 32'd1);

        // Reset mid-entry, then an illegal key
        press(5'h1); press(5'h2); press(5'hA); press(5'hC);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_code",  code_out,          32'h0);
        check("mid_rst_count", 32'(digit_count),  32'd0);
        check("mid_rst_valid", 32'(code_valid),   32'd0);
        check("mid_rst_err",   32'(entry_err),    32'd0);
        press(5'h15);
        check("illegal_err",   32'(entry_err),   32'd1);
        check("illegal_count", 32'(digit_count), 32'd0);
        @(negedge clk);
        check("illegal_pulse", 32'(entry_err), 32'd0);

`ifdef KEYPAD_TIMEOUT_EN
        press(5'h1);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_err",   32'(entry_err),   32'd1);
        check("tmo_count", 32'(digit_count), 32'd0);
        press(5'h1);
        repeat (TMO - 2) @(negedge clk);
        press(5'h2);
        check("tmo_key_err",   32'(entry_err),   32'd0);
        check("tmo_key_count", 32'(digit_count), 32'd2);
        press(K_CLR);
`else
        press(5'h3);
        repeat (TMO + 10) @(negedge clk);
        check("no_tmo_count", 32'(digit_count), 32'd1);
        check("no_tmo_err",   32'(entry_err),   32'd0);
        press(K_CLR);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
